// File: rtl/dmem_ctrl.sv
// Memory-stage data-bus controller: issues one held bus request per load/store,
// stalls the pipeline while busy, traps misaligned accesses and extends load data.
module dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_msize,
  input  logic        req_unsigned,
  input  logic [63:0] req_wd,
  input  logic [7:0]  req_strobe,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned STRBW = XLEN / 8;

  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic              r_unsigned;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_trap;
  logic              w_complete;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load;

  // Undefined sizes fall through to the default and are trapped as misaligned
  always_comb begin
    w_misaligned = 1'b1;
    case (req_msize)
      MSIZE1:  w_misaligned = 1'b0;
      MSIZE2:  w_misaligned = req_addr[0];
      MSIZE4:  w_misaligned = |req_addr[1:0];
      MSIZE8:  w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_misaligned ? S_DONE : S_BUSY;
      S_BUSY:  if (dresp_data_ok) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = 1'b0;
    w_trap     = 1'b0;
    w_complete = 1'b0;
    stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = req_valid & ~w_misaligned;
        w_trap   = req_valid &  w_misaligned;
        stall    = req_valid & ~reset;
      end
      S_BUSY: begin
        w_complete = dresp_data_ok;
        stall      = ~reset;
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the doubleword, then extend from its MSB
  always_comb begin
    w_shifted = dresp_data >> {dreq_addr[2:0], 3'b000};
    w_load    = '0;
    if (!r_write) begin
      case (dreq_size)
        MSIZE1:  w_load = {{(XLEN-8){w_shifted[7]   & ~r_unsigned}}, w_shifted[7:0]};
        MSIZE2:  w_load = {{(XLEN-16){w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
        MSIZE4:  w_load = {{(XLEN-32){w_shifted[31] & ~r_unsigned}}, w_shifted[31:0]};
        MSIZE8:  w_load = w_shifted;
        default: w_load = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      misalign    <= 1'b0;
    end else begin
      done <= w_trap | w_complete;
      if (w_accept) begin
        dreq_valid  <= 1'b1;
        dreq_addr   <= req_addr;
        dreq_size   <= req_msize;
        dreq_strobe <= req_write ? req_strobe : STRBW'(0);
        dreq_data   <= req_write ? req_wd : XLEN'(0);
        r_write     <= req_write;
        r_unsigned  <= req_unsigned;
      end else if (w_complete) begin
        dreq_valid <= 1'b0;
      end
      if (w_trap) begin
        misalign <= 1'b1;
        rdata    <= '0;
      end else if (w_complete) begin
        misalign <= 1'b0;
        rdata    <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads/stores with hand-computed results,
// misaligned traps, back-to-back requests and reset during a bus transaction.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [2:0]  req_msize;
  logic        req_unsigned;
  logic [63:0] req_wd;
  logic [7:0]  req_strobe;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;
  int n_bus_req = 0;
  logic prev_dreq_valid = 1'b0;

  dmem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_msize(req_msize), .req_unsigned(req_unsigned), .req_wd(req_wd),
    .req_strobe(req_strobe),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts distinct bus requests (rising edges of dreq_valid)
  always @(negedge clk) begin
    if (dreq_valid && !prev_dreq_valid) n_bus_req++;
    prev_dreq_valid = dreq_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid     = 1'b0;
      dresp_data_ok = 1'b1;
      dresp_data    = 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge clk);
      check("idle_done", 64'(done), 64'd0);
      check("idle_stall", 64'(stall), 64'd0);
      check("idle_dreq_valid", 64'(dreq_valid), 64'd0);
    end
  endtask

  // One aligned access: accept cycle, `waits` bus wait cycles, data_ok cycle, done cycle
  task automatic access(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [2:0] sz, input logic uns, input logic [63:0] wd,
                        input logic [7:0] sb, input int waits, input logic [63:0] resp,
                        input logic [63:0] exp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_msize = sz;
    req_unsigned = uns; req_wd = wd; req_strobe = sb;
    dresp_data_ok = 1'b0; dresp_data = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    check({tag, "_accept_stall"}, 64'(stall), 64'd1);
    check({tag, "_accept_dreq_valid"}, 64'(dreq_valid), 64'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      if (i == waits) begin
        dresp_data_ok = 1'b1;
        dresp_data    = resp;
      end
      @(negedge clk);
      check({tag, "_busy_dreq_valid"}, 64'(dreq_valid), 64'd1);
      check({tag, "_busy_stall"}, 64'(stall), 64'd1);
      check({tag, "_busy_addr"}, dreq_addr, addr);
      check({tag, "_busy_size"}, 64'(dreq_size), 64'(sz));
      check({tag, "_busy_strobe"}, 64'(dreq_strobe), wr ? 64'(sb) : 64'd0);
      check({tag, "_busy_data"}, dreq_data, wr ? wd : 64'd0);
      check({tag, "_busy_done"}, 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_misalign"}, 64'(misalign), 64'd0);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_done_stall"}, 64'(stall), 64'd0);
    check({tag, "_done_dreq_valid"}, 64'(dreq_valid), 64'd0);
  endtask

  task automatic trap(input string tag, input logic [63:0] addr, input logic [2:0] sz);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_msize = sz;
    req_unsigned = 1'b0; req_wd = '0; req_strobe = '0; dresp_data_ok = 1'b0;
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall), 64'd1);
    check({tag, "_dreq_valid0"}, 64'(dreq_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_misalign"}, 64'(misalign), 64'd1);
    check({tag, "_rdata"}, rdata, 64'd0);
    check({tag, "_dreq_valid1"}, 64'(dreq_valid), 64'd0);
    check({tag, "_done_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    int req_before;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_msize = '0; req_unsigned = 1'b0; req_wd = '0; req_strobe = '0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    #1 reset = 1'b0;
    idle_cycles(2);

    access("lb", 1'b0, 64'h0000_0000_8000_0005, 3'b000, 1'b0, '0, '0, 2,
           64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    access("lhu", 1'b0, 64'h0000_0000_0000_1006, 3'b001, 1'b1, '0, '0, 0,
           64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    access("lh", 1'b0, 64'h0000_0000_0000_1006, 3'b001, 1'b0, '0, '0, 1,
           64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
    access("sw", 1'b1, 64'h0000_0000_0000_2004, 3'b010, 1'b0, 64'h1234_5678_0000_0000,
           8'hF0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    trap("mis_d", 64'h0000_0000_0000_3003, 3'b011);
    access("lw", 1'b0, 64'h0000_0000_0000_4004, 3'b010, 1'b0, '0, '0, 0,
           64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    trap("mis_h", 64'h0000_0000_0000_5001, 3'b001);
    access("lwu", 1'b0, 64'h0000_0000_0000_4004, 3'b010, 1'b1, '0, '0, 0,
           64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    trap("mis_w", 64'h0000_0000_0000_6002, 3'b010);
    trap("bad_size", 64'h0000_0000_0000_7000, 3'b100);
    access("ld", 1'b0, 64'h0000_0000_0000_8008, 3'b011, 1'b0, '0, '0, 1,
           64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    access("lbu7", 1'b0, 64'h0000_0000_0000_9007, 3'b000, 1'b1, '0, '0, 0,
           64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5);
    idle_cycles(1);

    // Two loads with no gap: exactly two bus requests
    req_before = n_bus_req;
    access("b2b_a", 1'b0, 64'h0000_0000_0000_A000, 3'b011, 1'b0, '0, '0, 1,
           64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
    access("b2b_b", 1'b0, 64'h0000_0000_0000_A001, 3'b000, 1'b0, '0, '0, 0,
           64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);
    idle_cycles(1);
    check("b2b_bus_reqs", 64'(n_bus_req - req_before), 64'd2);

    // Reset in the middle of a bus transaction
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0000_0000_0000_B000;
    req_msize = 3'b011; req_unsigned = 1'b0; dresp_data_ok = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy_pre_valid", 64'(dreq_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rstbusy_valid", 64'(dreq_valid), 64'd0);
    check("rstbusy_stall", 64'(stall), 64'd0);
    check("rstbusy_done", 64'(done), 64'd0);
    req_valid = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    idle_cycles(2);
    access("post_rst", 1'b0, 64'h0000_0000_0000_C002, 3'b001, 1'b0, '0, '0, 0,
           64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    idle_cycles(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Memory-stage data-bus controller, directly downstream of the store-data aligner. Takes one load/store per instruction from the memory stage, including the aligner's already-positioned 64-bit store data and byte strobe. Drives a held-until-done data-bus request, stalls the pipeline while the bus is busy, and returns an extracted, sign/zero-extended load result. Misaligned accesses are trapped locally and never reach the bus.

## Interface
Parameters: none. msize encoding: MSIZE1=3'b000, MSIZE2=3'b001, MSIZE4=3'b010, MSIZE8=3'b011.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  memory stage holds a load/store this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_msize  in  3  access size
- req_unsigned  in  1  load zero-extends (lbu/lhu/lwu)
- req_wd  in  64  aligned store data from aligner
- req_strobe  in  8  byte strobe from aligner
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  request address (unmodified req_addr)
- dreq_size  out  3  request size
- dreq_strobe  out  8  store: req_strobe; load: 8'h00
- dreq_data  out  64  store: req_wd; load: 0
- dresp_data_ok  in  1  bus completes the request this cycle
- dresp_data  in  64  read data, full aligned doubleword
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse; result/misalign valid
- rdata  out  64  extended load result (0 for stores)
- misalign  out  1  valid with done; access misaligned

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE. All registered outputs reset to 0.
- IDLE, req_valid=0: stall=0, no action.
- IDLE, req_valid=1, aligned: latch write/addr/msize/unsigned/wd/strobe → BUSY. stall=1 combinationally this cycle.
- IDLE, req_valid=1, misaligned: no bus request. Set misalign=1, rdata=0 → DONE. stall=1 this cycle.
- Alignment rules: MSIZE2 needs addr[0]=0; MSIZE4 needs addr[1:0]=0; MSIZE8 needs addr[2:0]=0; MSIZE1 is always aligned.
- BUSY: dreq_* are driven from the latched registers, with dreq_valid=1 and stall=1. All dreq_* stay stable until dresp_data_ok.
- BUSY with dresp_data_ok=1: register rdata, set misalign=0 → DONE.
- rdata for a load: shift dresp_data right by addr[2:0]*8, take the low 8/16/32/64 bits, then sign-extend from the MSB (or zero-extend if unsigned). rdata for a store: 0.
- DONE: done=1, stall=0, and the pipeline advances. req_valid is ignored in DONE because the same instruction is still presented. Next state is IDLE unconditionally.
- dresp_data_ok outside BUSY: ignored.
- Undefined msize values (3'b1xx): treated as misaligned.

## Timing
- dreq_valid, dreq_*, done, rdata, misalign are registered. stall is combinational from state and req_*.
- Request accepted in cycle T (IDLE). dreq_valid=1 from T+1.
- dresp_data_ok in cycle T+k (k≥1) gives done and rdata at T+k+1. dreq_valid falls at T+k+1.
- Minimum load/store latency: done at T+2. Misaligned: done at T+1.
- Back-to-back: DONE at T+k+1 → IDLE at T+k+2. The next request is accepted at T+k+2. No bus request is issued in the DONE cycle.
- Asynchronous reset at any state forces IDLE immediately, with dreq_valid=0, stall=0, done=0. An in-flight bus transaction is abandoned, and the bus side tolerates it.

## Test plan
- Signed byte load: addr=0x80000005, MSIZE1, signed; dresp_data=0x0000_8000_0000_0000 (byte 5 = 0x80), data_ok 2 cycles after dreq_valid. Required: rdata=0xFFFF_FFFF_FFFF_FF80, done 1 cycle after data_ok, stall high throughout until the done cycle.
- Unsigned halfword load: addr=0x…6, MSIZE2, unsigned; dresp_data=0xBEEF_0000_0000_0000. Required: rdata=0x0000_0000_0000_BEEF.
- Word store: addr=0x…4, MSIZE4, req_wd=0x12345678_00000000, req_strobe=8'hF0. Required: dreq_strobe=8'hF0 and dreq_data unchanged, held stable for 5 wait cycles until data_ok; rdata=0.
- Misaligned doubleword: addr=0x…3, MSIZE8. Required: dreq_valid never asserts, done=1 and misalign=1 next cycle, rdata=0.
- Back-to-back and reset: two loads in sequence give exactly one bus request each, with no request in the DONE cycle. Reset asserted mid-BUSY drops dreq_valid and stall in the same cycle, and the FSM is in IDLE after release.
